// File: rtl/mac_accum_ctrl_pkg.sv
// MAC accumulate stage: shared widths and FSM encoding.
// Imported by the interface, the adder and the controller.
package mac_accum_ctrl_pkg;

  localparam int DEF_PROD_W = 32;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_e;

endpackage

// File: rtl/mac_accum_ctrl_if.sv
// Product-in / result-out bundle of the MAC accumulate stage.
// master drives jobs and products, slave is the accumulator.
interface mac_accum_ctrl_if
  import mac_accum_ctrl_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
);

  logic              start;
  logic [LEN_W-1:0]  len;
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res;
  logic              res_ovf;
  logic              busy;

  modport master (
    output start,
    output len,
    output prod_valid,
    output prod,
    output res_ready,
    input  prod_ready,
    input  res_valid,
    input  res,
    input  res_ovf,
    input  busy
  );

  modport slave (
    input  start,
    input  len,
    input  prod_valid,
    input  prod,
    input  res_ready,
    output prod_ready,
    output res_valid,
    output res,
    output res_ovf,
    output busy
  );

endinterface

// File: rtl/mac_sat_add.sv
// Saturating unsigned add of a product into the accumulator.
// Clamps to all-ones when the carry out of ACC_W bits is set.
module mac_sat_add
  import mac_accum_ctrl_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int PROD_W = DEF_PROD_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  localparam int W = ACC_W + 1;

  logic [W-1:0] full;

  assign full = {1'b0, acc} + W'(prod);
  assign ovf  = full[ACC_W];
  assign sum  = ovf ? '1 : full[ACC_W-1:0];

endmodule

// File: rtl/mac_accum_ctrl.sv
// Accumulate stage: sums LEN products per job into a saturating
// accumulator and hands out one result over valid/ready.
module mac_accum_ctrl
  import mac_accum_ctrl_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input logic              clk,
  input logic              rst,
  mac_accum_ctrl_if.slave  bus
);

  state_e             state_q;
  state_e             state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic               acc_we;
  logic [LEN_W-1:0]   cnt_q;
  logic [LEN_W-1:0]   cnt_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_d;
  logic               ovf_q;
  logic               ovf_d;
  logic [ACC_W-1:0]   sum;
  logic               carry;
  logic               accept;
  logic               last;

  mac_sat_add #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_add (
    .acc  (acc_q),
    .prod (bus.prod),
    .sum  (sum),
    .ovf  (carry)
  );

  assign accept = (state_q == ACCUM) && bus.prod_valid;
  assign last   = (cnt_q + 1'b1) == len_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    acc_we  = 1'b0;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d  = '0;
          acc_we = 1'b1;
          cnt_d  = '0;
          ovf_d  = 1'b0;
          if (bus.len != '0) begin
            len_d   = bus.len;
            state_d = ACCUM;
          end else begin
            state_d = RESULT;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d  = sum;
          acc_we = 1'b1;
          ovf_d  = ovf_q | carry;
          cnt_d  = cnt_q + 1'b1;
          if (last) begin
            state_d = RESULT;
          end
        end
      end
      RESULT: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  // Enabled only on job start and accepted beats so it stays quiet otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (acc_we) begin
      acc_q <= acc_d;
    end
  end

  assign bus.prod_ready = (state_q == ACCUM);
  assign bus.res_valid  = (state_q == RESULT);
  assign bus.busy       = (state_q != IDLE);
  assign bus.res        = acc_q;
  assign bus.res_ovf    = ovf_q;

endmodule

// File: tb/tb_mac_accum_ctrl.sv
// Bench for the MAC accumulate stage: table of jobs with a result
// scoreboard, plus saturation and mid-job reset sequences.
module tb_mac_accum_ctrl;

  logic clk;
  logic rst;

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mac_accum_ctrl_if #(.PROD_W(32), .ACC_W(40), .LEN_W(8)) b ();
  mac_accum_ctrl_if #(.PROD_W(8), .ACC_W(8), .LEN_W(8)) s ();

  mac_accum_ctrl #(
    .PROD_W (32),
    .ACC_W  (40),
    .LEN_W  (8)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  mac_accum_ctrl #(
    .PROD_W (8),
    .ACC_W  (8),
    .LEN_W  (8)
  ) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (s.slave)
  );

  typedef struct {
    int               len;
    logic [7:0][31:0] p;
    logic [15:0]      vpat;
    int               hold;
    logic [39:0]      eres;
    logic             eovf;
  } vec_t;

  typedef struct {
    logic [39:0] res;
    logic        ovf;
  } exp_t;

  vec_t tv [6];
  exp_t sbq [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic job(input vec_t v);
    logic [39:0] part;
    logic [39:0] hres;
    exp_t e;
    int n;
    int cyc;
    part = '0;
    b.start = 1'b1;
    b.len = 8'(v.len);
    sbq.push_back('{v.eres, v.eovf});
    step();
    b.start = 1'b0;
    n = 0;
    cyc = 0;
    while (n < v.len && cyc < 64) begin
      chk("prod_ready_accum", b.prod_ready, 1);
      chk("res_valid_early", b.res_valid, 0);
      b.prod_valid = v.vpat[cyc % 16];
      b.prod = v.p[n];
      step();
      if (b.prod_valid) begin
        part = part + 40'(v.p[n]);
        n++;
      end
      chk("acc_partial", b.res, part);
      cyc++;
    end
    b.prod_valid = 1'b0;
    chk("beats_done", n, v.len);
    chk("res_valid_rise", b.res_valid, 1);
    chk("prod_ready_result", b.prod_ready, 0);
    hres = b.res;
    for (int i = 0; i < v.hold; i++) begin
      b.start = 1'b1;
      b.len = 8'd5;
      step();
      chk("hold_valid", b.res_valid, 1);
      chk("hold_ready", b.prod_ready, 0);
      chk("hold_res", b.res, hres);
    end
    b.start = 1'b0;
    b.res_ready = 1'b1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sbq.pop_front();
      chk("sb_res", b.res, e.res);
      chk("sb_ovf", b.res_ovf, e.ovf);
    end
    step();
    b.res_ready = 1'b0;
    chk("back_idle", b.busy, 0);
    chk("idle_valid", b.res_valid, 0);
  endtask

  task automatic job8(input int len, input logic [7:0][7:0] p,
                      input logic [7:0] eres, input logic eovf);
    s.start = 1'b1;
    s.len = 8'(len);
    step();
    s.start = 1'b0;
    s.prod_valid = 1'b1;
    for (int i = 0; i < len; i++) begin
      s.prod = p[i];
      step();
    end
    s.prod_valid = 1'b0;
    chk("sat_valid", s.res_valid, 1);
    chk("sat_res", s.res, eres);
    chk("sat_ovf", s.res_ovf, eovf);
    s.res_ready = 1'b1;
    step();
    s.res_ready = 1'b0;
    chk("sat_idle", s.busy, 0);
  endtask

  initial begin
    logic [7:0][7:0] p8;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    b.start = 0; b.len = 0; b.prod_valid = 0; b.prod = 0; b.res_ready = 0;
    s.start = 0; s.len = 0; s.prod_valid = 0; s.prod = 0; s.res_ready = 0;

    tv[0] = '{3, '0, 16'hFFFF, 0, 40'd60, 1'b0};
    tv[0].p[0] = 10; tv[0].p[1] = 20; tv[0].p[2] = 30;
    tv[1] = '{4, '0, 16'h0059, 0, 40'd20, 1'b0};
    for (int i = 0; i < 4; i++) tv[1].p[i] = 5;
    tv[2] = '{0, '0, 16'hFFFF, 0, 40'd0, 1'b0};
    tv[3] = '{1, '0, 16'hFFFF, 5, 40'hFFFF_FFFF, 1'b0};
    tv[3].p[0] = 32'hFFFF_FFFF;
    tv[4] = '{5, '0, 16'hFFFF, 0, 40'h04_FFFF_FFFB, 1'b0};
    for (int i = 0; i < 5; i++) tv[4].p[i] = 32'hFFFF_FFFF;
    tv[5] = '{2, '0, 16'hFFFF, 2, 40'd15, 1'b0};
    tv[5].p[0] = 7; tv[5].p[1] = 8;

    step();
    step();
    chk("rst_busy", b.busy, 0);
    chk("rst_valid", b.res_valid, 0);
    chk("rst_ready", b.prod_ready, 0);
    chk("rst_res", b.res, 0);
    chk("rst_ovf", b.res_ovf, 0);
    chk("rst8_res", s.res, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) job(tv[i]);

    p8 = '0; p8[0] = 200; p8[1] = 100;
    job8(2, p8, 8'hFF, 1'b1);
    p8 = '0; p8[0] = 7;
    job8(1, p8, 8'd7, 1'b0);
    p8 = '0; p8[0] = 250; p8[1] = 10; p8[2] = 0;
    job8(3, p8, 8'hFF, 1'b1);

    b.start = 1'b1;
    b.len = 8'd4;
    step();
    b.start = 1'b0;
    b.prod_valid = 1'b1;
    b.prod = 32'd3;
    step();
    step();
    b.prod_valid = 1'b0;
    chk("mid_acc", b.res, 6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", b.busy, 0);
    chk("mid_rst_acc", b.res, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_rst_novalid", b.res_valid, 0);
    end
    tv[0] = '{1, '0, 16'hFFFF, 0, 40'd9, 1'b0};
    tv[0].p[0] = 9;
    job(tv[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
